safety_island_boot_ctrl: RTL and testbench

//   Boot sequencer of the safety island. After reset it samples the boot mode
//   and, in Jtag mode, zero-initialises (scrubs) all ECC-protected SRAM banks

---
 rtl/safety_island_pkg.sv | 18 +
 rtl/safety_island_boot_ctrl.sv | 79 +++++++
 tb/tb_safety_island_boot_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/safety_island_pkg.sv
// Shared types for the safety island: boot mode straps and boot controller FSM encoding.
package safety_island_pkg;

  typedef enum logic [1:0] {
    Jtag      = 2'b00,
    Preloaded = 2'b01
  } bootmode_e;

  typedef enum logic [2:0] {
    Reset  = 3'd0,
    Sample = 3'd1,
    Scrub  = 3'd2,
    Wait   = 3'd3,
    Launch = 3'd4,
    Run    = 3'd5
  } boot_ctrl_state_e;

endpackage

// File: rtl/safety_island_boot_ctrl.sv
// Boot sequencer: samples boot mode, zero-scrubs ECC SRAM in Jtag mode,
// then releases the core with a captured boot address.
module safety_island_boot_ctrl
  import safety_island_pkg::*;
#(
  parameter int unsigned          NumBanks     = 2,
  parameter int unsigned          BankNumBytes = 32'h0001_0000,
  parameter int unsigned          AddrWidth    = 32,
  parameter logic [AddrWidth-1:0] MemBaseAddr  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  bootmode_e            bootmode_i,
  input  logic [31:0]          soc_ctrl_boot_addr_i,
  input  logic                 soc_ctrl_fetch_en_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [31:0]          mem_wdata_o,
  output logic                 init_done_o,
  output logic                 fetch_en_o,
  output logic [31:0]          boot_addr_o
);

  localparam int unsigned TotalWords = NumBanks * BankNumBytes / 4;
  localparam int unsigned CntW       = (TotalWords > 1) ? $clog2(TotalWords) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TotalWords - 1);

  boot_ctrl_state_e  r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt;
  logic              r_init_done;
  logic [31:0]       r_boot_addr;
  logic              w_scrub_gnt;
  logic              w_last_gnt;

  assign w_scrub_gnt = (r_state == Scrub) && mem_gnt_i;
  assign w_last_gnt  = w_scrub_gnt && (r_cnt == LastCnt);

  // Anything other than Preloaded scrubs: an unscrubbed bank is the unsafe outcome.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      Reset:   w_state_nxt = Sample;
      Sample:  w_state_nxt = (bootmode_i == Preloaded) ? Launch : Scrub;
      Scrub:   if (w_last_gnt) w_state_nxt = Wait;
      Wait:    if (soc_ctrl_fetch_en_i) w_state_nxt = Launch;
      Launch:  w_state_nxt = Run;
      Run:     w_state_nxt = Run;
      default: w_state_nxt = Reset;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= Reset;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_boot_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter parks on the last word so the address never wraps back to bank 0.
      if (w_scrub_gnt && !w_last_gnt) r_cnt <= r_cnt + 1'b1;
      if (w_last_gnt || r_state == Launch) r_init_done <= 1'b1;
      if (r_state == Launch) r_boot_addr <= soc_ctrl_boot_addr_i;
    end
  end

  assign mem_req_o   = (r_state == Scrub);
  assign mem_we_o    = mem_req_o;
  assign mem_be_o    = 4'hF;
  assign mem_wdata_o = 32'h0;
  assign mem_addr_o  = MemBaseAddr + AddrWidth'({r_cnt, 2'b00});
  assign init_done_o = r_init_done;
  assign fetch_en_o  = (r_state == Run);
  assign boot_addr_o = r_boot_addr;

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Scenario bench for the boot controller with a small (2 x 64 B) scrub region.
module tb_safety_island_boot_ctrl;
  import safety_island_pkg::*;

  localparam int unsigned NB  = 2;
  localparam int unsigned BNB = 64;
  localparam int          TW  = NB * BNB / 4;

  logic        clk;
  logic        rst_ni;
  bootmode_e   bootmode_i;
  logic [31:0] boot_addr_i;
  logic        fen_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        init_done_o;
  logic        fetch_en_o;
  logic [31:0] boot_addr_o;

  int tests = 0;
  int fails = 0;

  safety_island_boot_ctrl #(
    .NumBanks(NB), .BankNumBytes(BNB), .AddrWidth(32), .MemBaseAddr(32'h0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bootmode_i(bootmode_i),
    .soc_ctrl_boot_addr_i(boot_addr_i), .soc_ctrl_fetch_en_i(fen_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .init_done_o(init_done_o), .fetch_en_o(fetch_en_o), .boot_addr_o(boot_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset(input bootmode_e mode, input logic fen);
    rst_ni     = 1'b0;
    bootmode_i = mode;
    fen_i      = fen;
    mem_gnt_i  = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Expected addresses queued up front; each granted request pops one.
  task automatic scrub_run(input int pct, input int abort_at, input int flip_at, output int nw);
    logic [31:0] exp_q[$];
    logic [31:0] exp_a;
    logic [31:0] prev_addr;
    logic        prev_stall;
    int          cyc;
    for (int i = 0; i < TW; i++) exp_q.push_back(32'(i * 4));
    nw = 0; prev_stall = 1'b0; prev_addr = '0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      tests++;
      if (fetch_en_o !== 1'b0 || init_done_o !== 1'b0) begin
        fails++;
        $display("FAIL scrub_flags: fetch_en=%b init_done=%b, required 0 0", fetch_en_o, init_done_o);
      end
      if (prev_stall) begin
        tests++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr) begin
          fails++;
          $display("FAIL stall_hold: req=%b addr=%h, required 1 %h", mem_req_o, mem_addr_o, prev_addr);
        end
      end
      if (mem_req_o === 1'b1) begin
        mem_gnt_i = ($urandom_range(99) < pct);
        if (mem_gnt_i) begin
          exp_a = exp_q.pop_front();
          tests++;
          if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {exp_a, 1'b1, 4'hF, 32'h0}) begin
            fails++;
            $display("FAIL scrub_write: addr=%h we=%b be=%h wdata=%h, required %h 1 f 0",
                     mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, exp_a);
          end
          nw++;
        end
        prev_stall = !mem_gnt_i;
        prev_addr  = mem_addr_o;
      end else begin
        mem_gnt_i  = 1'($urandom_range(1));
        prev_stall = 1'b0;
      end
      if (flip_at >= 0 && nw == flip_at) bootmode_i = Preloaded;
      if (abort_at >= 0 && nw == abort_at) break;
    end
    if (abort_at < 0) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL scrub_timeout: %0d words outstanding, required 0", exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    boot_addr_i = 32'h1234_5678;
    apply_reset(Jtag, 1'b1);
    rst_ni = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_req_o, mem_addr_o, init_done_o, fetch_en_o, boot_addr_o} !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_values: req=%b addr=%h done=%b fen=%b baddr=%h, required 0 0 0 0 0",
               mem_req_o, mem_addr_o, init_done_o, fetch_en_o, boot_addr_o);
    end
  endtask

  task automatic test_preloaded();
    boot_addr_i = 32'h1080;
    apply_reset(Preloaded, 1'b0);
    mem_gnt_i = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      tests++;
      if (fetch_en_o !== (e == 3) || mem_req_o !== 1'b0) begin
        fails++;
        $display("FAIL preload_edge%0d: fetch_en=%b req=%b, required %b 0", e, fetch_en_o, mem_req_o, e == 3);
      end
    end
    tests++;
    if (boot_addr_o !== 32'h1080 || init_done_o !== 1'b1) begin
      fails++;
      $display("FAIL preload_addr: baddr=%h done=%b, required 00001080 1", boot_addr_o, init_done_o);
    end
    boot_addr_i = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    tests++;
    if (boot_addr_o !== 32'h1080 || fetch_en_o !== 1'b1 || mem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL preload_hold: baddr=%h fen=%b req=%b, required 00001080 1 0", boot_addr_o, fetch_en_o, mem_req_o);
    end
  endtask

  task automatic test_jtag_basic();
    int nw;
    boot_addr_i = 32'h2000;
    apply_reset(Jtag, 1'b0);
    scrub_run(100, -1, -1, nw);
    tests++;
    if (nw != TW) begin fails++; $display("FAIL jtag_count: %0d writes, required %0d", nw, TW); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_gnt_i = 1'b1;
      tests++;
      if ({mem_req_o, init_done_o, fetch_en_o, mem_addr_o} !== {1'b0, 1'b1, 1'b0, 32'h7C}) begin
        fails++;
        $display("FAIL jtag_wait: req=%b done=%b fen=%b addr=%h, required 0 1 0 7c",
                 mem_req_o, init_done_o, fetch_en_o, mem_addr_o);
      end
    end
    fen_i = 1'b1;
    @(negedge clk);
    tests++;
    if (fetch_en_o !== 1'b0) begin fails++; $display("FAIL jtag_launch: fetch_en=%b, required 0", fetch_en_o); end
    @(negedge clk);
    tests++;
    if (fetch_en_o !== 1'b1 || boot_addr_o !== 32'h2000) begin
      fails++;
      $display("FAIL jtag_run: fen=%b baddr=%h, required 1 00002000", fetch_en_o, boot_addr_o);
    end
    boot_addr_i = 32'h3000;
    fen_i = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (fetch_en_o !== 1'b1 || boot_addr_o !== 32'h2000) begin
      fails++;
      $display("FAIL jtag_sticky: fen=%b baddr=%h, required 1 00002000", fetch_en_o, boot_addr_o);
    end
  endtask

  task automatic test_stall();
    int nw;
    apply_reset(Jtag, 1'b0);
    scrub_run(30, -1, -1, nw);
    tests++;
    if (nw != TW) begin fails++; $display("FAIL stall_count: %0d writes, required %0d", nw, TW); end
    @(negedge clk);
    tests++;
    if (mem_req_o !== 1'b0 || init_done_o !== 1'b1) begin
      fails++;
      $display("FAIL stall_done: req=%b done=%b, required 0 1", mem_req_o, init_done_o);
    end
  endtask

  task automatic test_early_fetch();
    int nw;
    boot_addr_i = 32'h4400;
    apply_reset(Jtag, 1'b1);
    scrub_run(100, -1, -1, nw);
    @(negedge clk);
    tests++;
    if (init_done_o !== 1'b1 || fetch_en_o !== 1'b0) begin
      fails++;
      $display("FAIL early_wait: done=%b fen=%b, required 1 0", init_done_o, fetch_en_o);
    end
    @(negedge clk);
    tests++;
    if (fetch_en_o !== 1'b0) begin fails++; $display("FAIL early_launch: fetch_en=%b, required 0", fetch_en_o); end
    @(negedge clk);
    tests++;
    if (fetch_en_o !== 1'b1 || boot_addr_o !== 32'h4400) begin
      fails++;
      $display("FAIL early_run: fen=%b baddr=%h, required 1 00004400", fetch_en_o, boot_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    int nw;
    apply_reset(Jtag, 1'b0);
    scrub_run(100, 10, -1, nw);
    @(negedge clk);
    tests++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h28) begin
      fails++;
      $display("FAIL mid_word10: req=%b addr=%h, required 1 00000028", mem_req_o, mem_addr_o);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({mem_req_o, mem_addr_o, init_done_o, fetch_en_o, boot_addr_o} !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL mid_reset: req=%b addr=%h done=%b fen=%b baddr=%h, required 0 0 0 0 0",
               mem_req_o, mem_addr_o, init_done_o, fetch_en_o, boot_addr_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    scrub_run(100, -1, -1, nw);
    tests++;
    if (nw != TW) begin fails++; $display("FAIL mid_restart: %0d writes, required %0d", nw, TW); end
  endtask

  task automatic test_mode11();
    int nw;
    boot_addr_i = 32'h5000;
    apply_reset(bootmode_e'(2'b11), 1'b0);
    scrub_run(50, -1, 5, nw);
    tests++;
    if (nw != TW) begin fails++; $display("FAIL mode11_count: %0d writes, required %0d", nw, TW); end
    fen_i = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (fetch_en_o !== 1'b1 || boot_addr_o !== 32'h5000 || init_done_o !== 1'b1) begin
      fails++;
      $display("FAIL mode11_run: fen=%b baddr=%h done=%b, required 1 00005000 1",
               fetch_en_o, boot_addr_o, init_done_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0; bootmode_i = Jtag; boot_addr_i = '0; fen_i = 1'b0; mem_gnt_i = 1'b0;
    test_reset();
    test_preloaded();
    test_jtag_basic();
    test_stall();
    test_early_fetch();
    test_reset_mid();
    test_mode11();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
